// File: rtl/act_loader_pkg.sv
// Shared sizing and FSM encoding for the activation loader and its buffer stage.
package act_loader_pkg;

    // Geometry shared with the activation buffer stage.
    localparam int AL_IF_WIDTH   = 16;
    localparam int AL_DATA_WIDTH = 8;
    localparam int AL_ADDR_WIDTH = 6;
    localparam int AL_CNT_WIDTH  = 7;

    // Loader FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/lane_nz_detect.sv
// Per-lane nonzero detection and popcount of the resulting flag word.
// Purely combinational; sits ahead of the loader's write register.
module lane_nz_detect
    import act_loader_pkg::*;
#(
    parameter int IF_WIDTH   = AL_IF_WIDTH,
    parameter int DATA_WIDTH = AL_DATA_WIDTH,
    parameter int CNT_WIDTH  = AL_CNT_WIDTH
) (
    input  logic [IF_WIDTH*DATA_WIDTH-1:0] lane_data,
    output logic [IF_WIDTH-1:0]            nz_flag,
    output logic [CNT_WIDTH-1:0]           nz_cnt
);

    logic [IF_WIDTH-1:0]  flag_s;
    logic [CNT_WIDTH-1:0] cnt_s;

    // Reduce each lane to a nonzero bit and accumulate the count of set flags.
    always_comb begin
        flag_s = '0;
        cnt_s  = '0;
        for (int i = 0; i < IF_WIDTH; i++) begin
            flag_s[i] = |lane_data[i*DATA_WIDTH +: DATA_WIDTH];
            cnt_s     = cnt_s + CNT_WIDTH'(flag_s[i]);
        end
    end

    assign nz_flag = flag_s;
    assign nz_cnt  = cnt_s;

endmodule

// File: rtl/act_loader.sv
// Activation loader: accepts dense rows over valid/ready, writes the per-lane
// nonzero flag word to the flag RAM and only the nonzero lanes to the
// per-column activation buffers, one registered write per accepted row.
module act_loader
    import act_loader_pkg::*;
#(
    parameter int IF_WIDTH   = AL_IF_WIDTH,
    parameter int DATA_WIDTH = AL_DATA_WIDTH,
    parameter int ADDR_WIDTH = AL_ADDR_WIDTH,
    parameter int CNT_WIDTH  = AL_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_WIDTH:0]            cfg_num_rows,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IF_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic                           wr_req_act_flag,
    output logic [IF_WIDTH-1:0]            wr_data_act_flag,
    output logic [IF_WIDTH-1:0]            wr_req_act,
    output logic [IF_WIDTH*DATA_WIDTH-1:0] wr_data_act,
    output logic [CNT_WIDTH-1:0]           row_nz_num,
    output logic                           busy,
    output logic                           load_done
);

    // Control state.
    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [ADDR_WIDTH:0]   num_rows_r;
    logic [ADDR_WIDTH:0]   num_rows_nxt_s;
    logic [ADDR_WIDTH:0]   row_cnt_r;
    logic [ADDR_WIDTH:0]   row_cnt_nxt_s;
    logic                  in_ready_r;
    logic                  busy_r;
    logic                  load_done_r;
    logic                  hs_s;

    // Write pipeline register.
    logic                           wr_req_flag_r;
    logic [IF_WIDTH-1:0]            wr_flag_r;
    logic [IF_WIDTH-1:0]            wr_req_act_r;
    logic [IF_WIDTH*DATA_WIDTH-1:0] wr_data_r;
    logic [CNT_WIDTH-1:0]           nz_num_r;

    // Combinational detector outputs for the row currently on in_data.
    logic [IF_WIDTH-1:0]  lane_flag_s;
    logic [CNT_WIDTH-1:0] lane_cnt_s;

    lane_nz_detect #(
        .IF_WIDTH   (IF_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_lane_nz_detect (
        .lane_data (in_data),
        .nz_flag   (lane_flag_s),
        .nz_cnt    (lane_cnt_s)
    );

    // in_ready is registered from the next state, so it is only high in LOAD.
    assign hs_s = in_valid & in_ready_r;

    // Next-state, row-count and row-limit logic for the load sequence.
    always_comb begin
        state_nxt_s    = state_r;
        num_rows_nxt_s = num_rows_r;
        row_cnt_nxt_s  = row_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    num_rows_nxt_s = cfg_num_rows;
                    row_cnt_nxt_s  = '0;
                    if (cfg_num_rows == '0) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    row_cnt_nxt_s = row_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
                    // Beat just accepted is the last row when count+1 reaches the limit.
                    if ((row_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1}) == num_rows_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Control registers; status outputs are derived from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            num_rows_r  <= '0;
            row_cnt_r   <= '0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
            load_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            num_rows_r  <= num_rows_nxt_s;
            row_cnt_r   <= row_cnt_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_LOAD);
            busy_r      <= (state_nxt_s != ST_IDLE);
            load_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Write stage: strobes follow the handshake; data, flags and count hold between writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_req_flag_r <= 1'b0;
            wr_req_act_r  <= '0;
            wr_flag_r     <= '0;
            wr_data_r     <= '0;
            nz_num_r      <= '0;
        end else begin
            wr_req_flag_r <= hs_s;
            wr_req_act_r  <= hs_s ? lane_flag_s : '0;
            if (hs_s) begin
                wr_flag_r <= lane_flag_s;
                wr_data_r <= in_data;
                nz_num_r  <= lane_cnt_s;
            end
        end
    end

    assign in_ready         = in_ready_r;
    assign busy             = busy_r;
    assign load_done        = load_done_r;
    assign wr_req_act_flag  = wr_req_flag_r;
    assign wr_data_act_flag = wr_flag_r;
    assign wr_req_act       = wr_req_act_r;
    assign wr_data_act      = wr_data_r;
    assign row_nz_num       = nz_num_r;

endmodule
